// File: rtl/banked_dp_ram.sv
// -----------------------------------------------------------------------------
// banked_dp_ram
//
// Multi-bank, true dual-port synchronous RAM. Port A serves the datapath /
// load-store unit and port B serves the I/O / VGA side. The word address space
// is split into NUM_BANKS equal banks. The upper BANK_BITS address bits select
// the bank and the remaining bits index into it.
//
// After reset, a clear engine writes CLEAR_VALUE to every location. It writes
// all banks in parallel, one index per cycle, through the port-A write path.
// While the clear runs, ready is low and all requests are ignored.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high reset
//   en_a/b     request strobe
//   we_a/b     write enable (qualified by en_x)
//   addr_a/b   full word address (bank + index)
//   data_a/b   write data
//   q_a/b      read data; holds its last value when no read completes
//   valid_a/b  single-cycle pulse marking a completed read
//   ready      high once the clear sweep has finished
//   collision  pulse when a same-address port B write was dropped
//
// Optional build macro:
//   BANKED_DP_RAM_OUTREG_EN  adds an output register stage on q/valid/collision.
//                            Read latency becomes 2 cycles.
// -----------------------------------------------------------------------------
module banked_dp_ram #(
    parameter int                    DATA_WIDTH  = 16,
    parameter int                    ADDR_WIDTH  = 10,
    parameter int                    NUM_BANKS   = 2,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en_a,
    input  logic                  we_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] data_a,
    output logic [DATA_WIDTH-1:0] q_a,
    output logic                  valid_a,
    input  logic                  en_b,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] data_b,
    output logic [DATA_WIDTH-1:0] q_b,
    output logic                  valid_b,
    output logic                  ready,
    output logic                  collision
);

    localparam int BANK_BITS  = $clog2(NUM_BANKS);
    localparam int IDX_W      = ADDR_WIDTH - BANK_BITS;
    localparam int BANK_DEPTH = 1 << IDX_W;
    // Bank-select signals need at least one bit even when there is a single bank.
    localparam int SEL_W      = (BANK_BITS > 0) ? BANK_BITS : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = '1;

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   clr_cnt_reg, clr_cnt_next;
    logic               clearing;

    logic [SEL_W-1:0]   bank_a, bank_b;
    logic [IDX_W-1:0]   idx_a, idx_b;
    logic               wr_a, wr_b, rd_a, rd_b;
    logic               coll_hit, wr_b_eff;
    logic [IDX_W-1:0]   wa_idx;
    logic [DATA_WIDTH-1:0] wa_data;

    logic [DATA_WIDTH-1:0] bank_q_a [NUM_BANKS];
    logic [DATA_WIDTH-1:0] bank_q_b [NUM_BANKS];
    logic [SEL_W-1:0]   bank_sel_a_reg, bank_sel_b_reg;
    logic               valid_a_reg, valid_b_reg, collision_reg;
    logic [DATA_WIDTH-1:0] q_a_mux, q_b_mux;

    // ---------------- clear / ready FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_CLEAR;
            clr_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clr_cnt_reg <= clr_cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        clr_cnt_next = clr_cnt_reg;
        case (state_reg)
            ST_CLEAR: begin
                clr_cnt_next = clr_cnt_reg + 1'b1;
                if (clr_cnt_reg == LAST_IDX) begin
                    state_next   = ST_READY;
                    clr_cnt_next = '0;
                end
            end
            ST_READY: state_next = ST_READY;
            default:  state_next = ST_CLEAR;
        endcase
    end

    assign clearing = (state_reg == ST_CLEAR);
    assign ready    = (state_reg == ST_READY);

    // ---------------- address decode / request qualification ----------------
    // Shifting by the index width leaves just the bank bits (zero for one bank).
    assign bank_a = SEL_W'(addr_a >> IDX_W);
    assign bank_b = SEL_W'(addr_b >> IDX_W);
    assign idx_a  = addr_a[IDX_W-1:0];
    assign idx_b  = addr_b[IDX_W-1:0];

    assign wr_a = ready & en_a & we_a;
    assign rd_a = ready & en_a & ~we_a;
    assign wr_b = ready & en_b & we_b;
    assign rd_b = ready & en_b & ~we_b;

    // Port A wins a same-address write; port B's write is dropped.
    assign coll_hit = wr_a & wr_b & (addr_a == addr_b);
    assign wr_b_eff = wr_b & ~coll_hit;

    // The clear engine borrows the port-A write path in every bank.
    assign wa_idx  = clearing ? clr_cnt_reg : idx_a;
    assign wa_data = clearing ? CLEAR_VALUE : data_a;

    // ---------------- banks ----------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            logic [DATA_WIDTH-1:0] mem [BANK_DEPTH];
            logic [DATA_WIDTH-1:0] rdata_a_reg, rdata_b_reg;
            logic                  hit_a, hit_b;
            logic                  we_a_bank, we_b_bank;

            assign hit_a     = (bank_a == SEL_W'(gi));
            assign hit_b     = (bank_b == SEL_W'(gi));
            assign we_a_bank = clearing | (wr_a & hit_a);
            assign we_b_bank = wr_b_eff & hit_b;

            always_ff @(posedge clk) begin
                if (we_a_bank)
                    mem[wa_idx] <= wa_data;
                if (we_b_bank)
                    mem[idx_b] <= data_b;
            end

            // Read registers only load on a read to this bank, so the selected
            // bank output stays put between reads (read-first across ports).
            always_ff @(posedge clk) begin
                if (reset) begin
                    rdata_a_reg <= '0;
                    rdata_b_reg <= '0;
                end else begin
                    if (rd_a && hit_a)
                        rdata_a_reg <= mem[idx_a];
                    if (rd_b && hit_b)
                        rdata_b_reg <= mem[idx_b];
                end
            end

            assign bank_q_a[gi] = rdata_a_reg;
            assign bank_q_b[gi] = rdata_b_reg;
        end
    endgenerate

    // ---------------- bank select pipeline / valid / collision ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            bank_sel_a_reg <= '0;
            bank_sel_b_reg <= '0;
            valid_a_reg    <= 1'b0;
            valid_b_reg    <= 1'b0;
            collision_reg  <= 1'b0;
        end else begin
            if (rd_a)
                bank_sel_a_reg <= bank_a;
            if (rd_b)
                bank_sel_b_reg <= bank_b;
            valid_a_reg   <= rd_a;
            valid_b_reg   <= rd_b;
            collision_reg <= coll_hit;
        end
    end

    assign q_a_mux = bank_q_a[bank_sel_a_reg];
    assign q_b_mux = bank_q_b[bank_sel_b_reg];

`ifdef BANKED_DP_RAM_OUTREG_EN
    logic [DATA_WIDTH-1:0] q_a_out_reg, q_b_out_reg;
    logic                  valid_a_out_reg, valid_b_out_reg, collision_out_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            q_a_out_reg       <= '0;
            q_b_out_reg       <= '0;
            valid_a_out_reg   <= 1'b0;
            valid_b_out_reg   <= 1'b0;
            collision_out_reg <= 1'b0;
        end else begin
            q_a_out_reg       <= q_a_mux;
            q_b_out_reg       <= q_b_mux;
            valid_a_out_reg   <= valid_a_reg;
            valid_b_out_reg   <= valid_b_reg;
            collision_out_reg <= collision_reg;
        end
    end

    assign q_a       = q_a_out_reg;
    assign q_b       = q_b_out_reg;
    assign valid_a   = valid_a_out_reg;
    assign valid_b   = valid_b_out_reg;
    assign collision = collision_out_reg;
`else
    assign q_a       = q_a_mux;
    assign q_b       = q_b_mux;
    assign valid_a   = valid_a_reg;
    assign valid_b   = valid_b_reg;
    assign collision = collision_reg;
`endif

endmodule
